// File: rtl/adder_mul_seq.sv
// Sequential shift-and-add multiplier: one partial product per clock through a
// single 16-bit carry-lookahead adder, with a fixed WIDTH+1 edge latency to done.
module adder_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [15:0]        acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [15:0] add_b;
    logic [15:0] add_sum;
    logic        adder_c16_unused;

    // Skipped partial products still go through the adder with a zero operand,
    // so acc always has exactly one source in RUN.
    assign add_b = (state_q == S_RUN && mplr_q[0]) ? mcand_q : 16'd0;

    bit16adder u_adder (
        .a   (acc_q),
        .b   (add_b),
        .c0  (1'b0),
        .s   (add_sum),
        .c16 (adder_c16_unused)
    );

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = {{(16-WIDTH){1'b0}}, a};
                    mplr_d  = b;
                    acc_d   = 16'd0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d   = add_sum;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d   = S_DONE;
                    product_d = add_sum[2*WIDTH-1:0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mcand_q   <= 16'd0;
            mplr_q    <= '0;
            acc_q     <= 16'd0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign product = product_q;

endmodule

// 16-bit carry-lookahead adder: four 4-bit lookahead groups under a second-level
// group carry unit.
module bit16adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c0,
    output logic [15:0] s,
    output logic        c16
);

    logic [15:0] g, p;
    logic [3:0]  gg, gp;
    logic [4:0]  gc;

    assign g = a & b;
    assign p = a ^ b;

    for (genvar k = 0; k < 4; k++) begin : g_grp
        logic [3:0] gi, pi, c;
        assign gi   = g[4*k +: 4];
        assign pi   = p[4*k +: 4];
        assign c[0] = gc[k];
        assign c[1] = gi[0] | (pi[0] & c[0]);
        assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & c[0]);
        assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
                    | (pi[2] & pi[1] & pi[0] & c[0]);
        assign gg[k] = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
                     | (pi[3] & pi[2] & pi[1] & gi[0]);
        assign gp[k] = &pi;
        assign s[4*k +: 4] = pi ^ c;
    end

    assign gc[0] = c0;
    assign gc[1] = gg[0] | (gp[0] & c0);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c0);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & c0);
    assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & c0);
    assign c16 = gc[4];

endmodule

// File: tb/tb_adder_mul_seq.sv
// Directed and random checks of adder_mul_seq (WIDTH=8): latency, product,
// ignored starts, asynchronous reset mid-operation and busy/done exclusivity.
module tb_adder_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int errors = 0;
    int checks = 0;

    adder_mul_seq #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one operation from IDLE and returns one edge after done (back in IDLE).
    // edges counts clock edges from the start edge (inclusive) to the edge after
    // which done is seen; viol counts busy&done overlaps and double-done cycles.
    task automatic do_mul(input logic [7:0] ia, input logic [7:0] ib,
                          output logic [15:0] p, output int edges, output int bcnt,
                          output bit got, output bit stable, output int viol);
        logic [15:0] p0;
        p0 = product; p = 16'hxxxx; got = 0; stable = 1; viol = 0; bcnt = 0;
        start = 1'b1; a = ia; b = ib;
        @(posedge clk); #1;
        start = 1'b0; edges = 1;
        while (edges < 40) begin
            if (busy && done) viol++;
            if (done) begin got = 1; p = product; break; end
            if (product !== p0) stable = 0;
            if (busy) bcnt++;
            a = 8'($urandom); b = 8'($urandom);
            @(posedge clk); #1; edges++;
        end
        @(posedge clk); #1;
        if (done || busy) viol++;
    endtask

    task automatic test_reset;
        start = 1'b0; a = 8'd0; b = 8'd0; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b product=%h, need 0 0 0000", busy, done, product);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic [15:0] p; int e, bc, v; bit g, s;
        do_mul(8'd13, 8'd11, p, e, bc, g, s, v);
        checks++;
        if (!g) begin errors++; $display("FAIL basic_timeout: no done within 40 edges"); end
        checks++;
        if (p !== 16'd143) begin errors++; $display("FAIL basic_product: got %0d need 143", p); end
        checks++;
        if (e !== 9) begin errors++; $display("FAIL basic_latency: got %0d edges need 9", e); end
        checks++;
        if (bc !== 8) begin errors++; $display("FAIL basic_busy_len: got %0d cycles need 8", bc); end
        checks++;
        if (v !== 0) begin errors++; $display("FAIL basic_excl: %0d violations need 0", v); end
        checks++;
        if (product !== 16'd143) begin errors++; $display("FAIL basic_hold: got %0d need 143", product); end
    endtask

    task automatic test_extremes;
        logic [7:0]  ta [3] = '{8'd255, 8'd0,   8'd1};
        logic [7:0]  tb [3] = '{8'd255, 8'd200, 8'd1};
        logic [15:0] te [3] = '{16'hFE01, 16'd0, 16'd1};
        logic [15:0] p; int e, bc, v; bit g, s;
        for (int i = 0; i < 3; i++) begin
            do_mul(ta[i], tb[i], p, e, bc, g, s, v);
            checks++;
            if (!g || p !== te[i] || e !== 9) begin
                errors++;
                $display("FAIL extreme_%0d: %0d*%0d got %h at %0d edges (done=%b) need %h at 9",
                         i, ta[i], tb[i], p, e, g, te[i]);
            end
        end
    endtask

    task automatic test_ignored_start;
        int ndone = 0; int late_busy = 0;
        logic [15:0] pd = 16'hxxxx;
        start = 1'b1; a = 8'd7; b = 8'd9;
        @(posedge clk); #1;
        for (int k = 1; k <= 14; k++) begin
            if (done) begin ndone++; pd = product; end
            if (k >= 10 && busy) late_busy++;
            start = (k == 3 || k == 8 || done);
            if (start) begin a = 8'd3; b = 8'd3; end
            else begin a = 8'($urandom); b = 8'($urandom); end
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++;
        if (ndone !== 1) begin errors++; $display("FAIL ignored_done_count: got %0d need 1", ndone); end
        checks++;
        if (pd !== 16'd63) begin errors++; $display("FAIL ignored_product: got %0d need 63", pd); end
        checks++;
        if (late_busy !== 0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ignored_idle: late_busy=%0d busy=%b done=%b need 0 0 0", late_busy, busy, done);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] p; int e, bc, v; bit g, s;
        int ndone = 0;
        start = 1'b1; a = 8'd100; b = 8'd100;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'd0) begin
            errors++;
            $display("FAIL midreset_state: busy=%b done=%b product=%h need 0 0 0000", busy, done, product);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 12; k++) begin
            if (done || busy) ndone++;
            @(posedge clk); #1;
        end
        checks++;
        if (ndone !== 0) begin errors++; $display("FAIL midreset_no_done: %0d active cycles need 0", ndone); end
        do_mul(8'd2, 8'd3, p, e, bc, g, s, v);
        checks++;
        if (!g || p !== 16'd6 || e !== 9) begin
            errors++;
            $display("FAIL midreset_restart: got %0d at %0d edges (done=%b) need 6 at 9", p, e, g);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  ta [3] = '{8'd12, 8'd255, 8'd128};
        logic [7:0]  tb [3] = '{8'd12, 8'd1,   8'd2};
        logic [15:0] te [3] = '{16'd144, 16'd255, 16'd256};
        logic [15:0] p; int e, bc, v; bit g, s;
        for (int i = 0; i < 3; i++) begin
            do_mul(ta[i], tb[i], p, e, bc, g, s, v);
            checks++;
            if (!g || p !== te[i] || e !== 9) begin
                errors++;
                $display("FAIL b2b_%0d: got %0d at %0d edges (done=%b) need %0d at 9", i, p, e, g, te[i]);
            end
            checks++;
            if (!s || v !== 0) begin
                errors++;
                $display("FAIL b2b_hold_%0d: stable=%b viol=%0d need 1 0", i, s, v);
            end
        end
    endtask

    task automatic test_random;
        logic [15:0] p; int e, bc, v; bit g, s;
        logic [7:0] ra, rb;
        logic [15:0] exp_p;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            exp_p = 16'(ra) * 16'(rb);
            do_mul(ra, rb, p, e, bc, g, s, v);
            checks++;
            if (!g || p !== exp_p || e !== 9 || v !== 0) begin
                errors++;
                $display("FAIL random_%0d: %0d*%0d got %0d at %0d edges viol=%0d need %0d at 9",
                         i, ra, rb, p, e, v, exp_p);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_mul_seq.md
# adder_mul_seq

Sequential unsigned shift-and-add multiplier built around one instance of the team's 16-bit carry-lookahead adder (`bit16adder`, carry-in tied 0). A control FSM feeds the adder with an accumulator and a shifted multiplicand, one partial product per clock, and produces a 2·WIDTH-bit product after a fixed latency. This is the first sequencing controller layered on the combinational adder datapath. It is also the template for later multi-cycle arithmetic units.

## Interface
- WIDTH, 8, operand width in bits; legal 1..8 so the product fits the 16-bit adder.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  multiplicand, sampled with accepted start
- b  in  WIDTH  multiplier, sampled with accepted start
- busy  out  1  high while state is RUN
- done  out  1  one-cycle pulse, product valid
- product  out  2·WIDTH  registered result, held until the next result

## Operation
- Single clock; reset is asynchronous and active-low.
- Registers:
  - mcand[15:0]: multiplicand, zero-extended.
  - mplr[WIDTH-1:0]: multiplier.
  - acc[15:0]: accumulator.
  - cnt: counter of ceil(log2(WIDTH+1)) bits.
  - state.
  - product[2·WIDTH-1:0].
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1, load mcand={0,a}, mplr=b, acc=0, cnt=0, then go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - If mplr[0]=1, acc <= adder sum(acc, mcand). Otherwise acc is unchanged. Adder operands are gated to acc and 0 rather than bypassing the adder.
  - mcand <= mcand<<1, mplr <= mplr>>1, cnt <= cnt+1.
  - When cnt=WIDTH-1 (the last iteration), go to DONE. On that same edge, product <= the final acc value, including the last conditional add.
- DONE:
  - done=1 for this one cycle, then go to IDLE unconditionally.
  - start in DONE is ignored.
- Width rule: the adder's carry out (c16) is unused and discarded. For WIDTH≤8 the product fits in 2·WIDTH bits, so no overflow can occur. product takes acc[2·WIDTH-1:0].
- start while busy or in DONE: no effect on operands, state or outputs. The caller must hold or re-issue start after done.
- a and b are don't-care except on the accepting edge. Changes during RUN must not affect the result.
- Reset (asynchronous, any state, including mid-RUN):
  - state=IDLE, busy=0, done=0, product=0, acc=0, mcand=0, mplr=0, cnt=0.
  - An operation in progress is lost, and no done is produced for it.
  - After rst_n rises, the first start is accepted normally.

## Timing
- Edge E0 samples start=1 in IDLE. RUN iterations occur on edges E1..E_WIDTH.
  - busy=1 from after E0 until E_WIDTH.
  - state=DONE and done=1 in the cycle after E_WIDTH.
  - product is valid from that cycle onward.
- Latency: start edge to done high is WIDTH+1 edges, which is 9 for WIDTH=8. It is constant and independent of operand values.
- Throughput: the earliest next start is accepted at the edge after done, i.e. once state is IDLE. One result is produced per WIDTH+2 cycles.
- busy and done are never high together. done is never high for two consecutive cycles.
- The combinational path per cycle is acc/mcand through the 16-bit adder into acc. There is no other arithmetic in the path.
- Reset values: busy=0, done=0, product=0.

## Test plan
- Basic: reset, then start with a=13, b=11 (WIDTH=8). Expect done exactly 9 edges after the start edge, product=143 (0x008F), busy high for 8 cycles.
- Extremes:
  - a=255, b=255 gives product=65025 (0xFE01), with no carry-out loss.
  - a=0, b=200 gives 0.
  - a=1, b=1 gives 1.
- Ignored start:
  - Start a=7, b=9. Pulse start with a=3, b=3 at cycles 3 and 8 of RUN, and again in the DONE cycle. Expect a single done, product=63, and state IDLE afterwards.
  - Operands changed during RUN must not alter the result.
- Reset mid-operation:
  - Start a=100, b=100. Assert rst_n=0 asynchronously (off clock edge) at RUN cycle 4. Expect immediate busy=0, done=0, product=0, and no done.
  - Release reset, then start a=2, b=3. Expect product=6 after 9 edges.
- Back-to-back: issue start on the edge after each done with pairs (12,12), (255,1), (128,2). Expect results 144, 255, 256, each product held stable until the next done.
- Random: 1000 random a,b pairs against a reference a·b. Check every result, and check busy/done exclusivity every cycle.
